multicycle_control_unit: RTL and testbench

- Main FSM of the multicycle RV32I core; sits directly upstream of the ALU control unit.
- Sequences fetch/decode/execute/memory/writeback from the 7-bit opcode.
- Drives all datapath write enables and mux selects.
- Drives the ALU control unit's alu_op_from_ctrl/enable pair: enable=1 makes that unit decode funct fields; enable=0 passes alu_op through unchanged.

---
 rtl/multicycle_control_unit.sv | 225 ++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Main FSM of the multicycle RV32I core.
// Sequences IF/ID/EX/MEM/WB and drives every datapath enable and mux select.
module multicycle_control_unit #(
  parameter int ALU_OP_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              opcode,
  input  logic                    ecall_halt,
  input  logic                    alu_bcond,
  input  logic                    mem_ready,
  output logic                    pc_write,
  output logic                    pc_source,
  output logic                    i_or_d,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic                    ir_write,
  output logic                    mdr_write,
  output logic                    reg_write,
  output logic [1:0]              wb_src,
  output logic                    alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic                    alu_out_write,
  output logic [ALU_OP_WIDTH-1:0] alu_op,
  output logic                    alu_ctrl_enable,
  output logic [2:0]              state,
  output logic                    inst_retired,
  output logic                    is_halted
);

  localparam logic [6:0] OP_ARITH  = 7'b0110011;
  localparam logic [6:0] OP_ARITHI = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = '0;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC4    = 2'd2;
  localparam logic [1:0] SRCB_B    = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_4    = 2'd2;

  typedef enum logic [2:0] {
    S_IF     = 3'd0,
    S_ID     = 3'd1,
    S_EX     = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_PC_INC = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  state_e state_q, state_d;
  logic   retired_q, retired_d;
  logic   known_op;

  assign known_op = opcode inside {
    OP_ARITH, OP_ARITHI, OP_LOAD, OP_STORE,
    OP_BRANCH, OP_JAL, OP_JALR, OP_ECALL
  };

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IF;
      retired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    pc_write        = 1'b0;
    pc_source       = 1'b0;
    i_or_d          = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    ir_write        = 1'b0;
    mdr_write       = 1'b0;
    reg_write       = 1'b0;
    wb_src          = WB_ALUOUT;
    alu_src_a       = 1'b0;
    alu_src_b       = SRCB_B;
    alu_out_write   = 1'b0;
    alu_op          = ALU_ADD;
    alu_ctrl_enable = 1'b0;

    unique case (state_q)
      S_IF: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          state_d  = S_ID;
        end
      end
      S_ID: begin
        alu_src_b     = SRCB_IMM;
        alu_out_write = 1'b1;
        if (opcode == OP_ECALL)
          state_d = ecall_halt ? S_HALT : S_PC_INC;
        else if (!known_op)
          state_d = S_PC_INC;
        else
          state_d = S_EX;
      end
      S_EX: begin
        unique case (opcode)
          OP_ARITH, OP_ARITHI: begin
            alu_src_a       = 1'b1;
            alu_src_b       = (opcode == OP_ARITH) ? SRCB_B : SRCB_IMM;
            alu_ctrl_enable = 1'b1;
            alu_out_write   = 1'b1;
            state_d         = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a     = 1'b1;
            alu_src_b     = SRCB_IMM;
            alu_out_write = 1'b1;
            state_d       = S_MEM;
          end
          OP_BRANCH: begin
            alu_src_a       = 1'b1;
            alu_ctrl_enable = 1'b1;
            if (alu_bcond) begin
              pc_write  = 1'b1;
              pc_source = 1'b1;
              state_d   = S_IF;
            end else begin
              state_d = S_PC_INC;
            end
          end
          OP_JAL: begin
            alu_src_b = SRCB_4;
            reg_write = 1'b1;
            wb_src    = WB_PC4;
            pc_write  = 1'b1;
            pc_source = 1'b1;
            state_d   = S_IF;
          end
          OP_JALR: begin
            alu_src_a     = 1'b1;
            alu_src_b     = SRCB_IMM;
            alu_out_write = 1'b1;
            state_d       = S_WB;
          end
          default: state_d = S_PC_INC;
        endcase
      end
      S_MEM: begin
        // ALUOut holds the address for the whole wait
        i_or_d = 1'b1;
        if (opcode == OP_LOAD) begin
          mem_read = 1'b1;
          if (mem_ready) begin
            mdr_write = 1'b1;
            state_d   = S_WB;
          end
        end else begin
          mem_write = 1'b1;
          if (mem_ready) begin
            alu_src_b = SRCB_4;
            pc_write  = 1'b1;
            state_d   = S_IF;
          end
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        alu_src_b = SRCB_4;
        pc_write  = 1'b1;
        state_d   = S_IF;
        unique case (opcode)
          OP_LOAD: wb_src = WB_MDR;
          OP_JALR: begin
            wb_src    = WB_PC4;
            pc_source = 1'b1;
          end
          default: wb_src = WB_ALUOUT;
        endcase
      end
      S_PC_INC: begin
        alu_src_b = SRCB_4;
        pc_write  = 1'b1;
        state_d   = S_IF;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase

    retired_d    = (state_d == S_IF) && (state_q != S_IF);
    state        = state_q;
    inst_retired = retired_q;
    is_halted    = (state_q == S_HALT);

    if (reset) begin
      state_d         = S_IF;
      retired_d       = 1'b0;
      pc_write        = 1'b0;
      pc_source       = 1'b0;
      i_or_d          = 1'b0;
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      ir_write        = 1'b0;
      mdr_write       = 1'b0;
      reg_write       = 1'b0;
      wb_src          = WB_ALUOUT;
      alu_src_a       = 1'b0;
      alu_src_b       = SRCB_B;
      alu_out_write   = 1'b0;
      alu_op          = ALU_ADD;
      alu_ctrl_enable = 1'b0;
      state           = 3'd0;
      inst_retired    = 1'b0;
      is_halted       = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed table-driven bench for multicycle_control_unit.
// Each row is one clock cycle: inputs plus the expected packed outputs.
module tb_multicycle_control_unit;

  logic       clk;
  logic       reset;
  logic [6:0] opcode;
  logic       ecall_halt, alu_bcond, mem_ready;
  logic       pc_write, pc_source, i_or_d, mem_read, mem_write;
  logic       ir_write, mdr_write, reg_write;
  logic [1:0] wb_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       alu_out_write;
  logic [3:0] alu_op;
  logic       alu_ctrl_enable;
  logic [2:0] state;
  logic       inst_retired, is_halted;

  multicycle_control_unit #(.ALU_OP_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .ecall_halt(ecall_halt), .alu_bcond(alu_bcond),
    .mem_ready(mem_ready), .pc_write(pc_write),
    .pc_source(pc_source), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mdr_write(mdr_write),
    .reg_write(reg_write), .wb_src(wb_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_out_write(alu_out_write), .alu_op(alu_op),
    .alu_ctrl_enable(alu_ctrl_enable), .state(state),
    .inst_retired(inst_retired), .is_halted(is_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed observation: [23:21] state, then controls down to is_halted
  logic [23:0] ov;
  assign ov = {state, pc_write, pc_source, i_or_d,
               mem_read, mem_write, ir_write, mdr_write,
               reg_write, wb_src, alu_src_a, alu_src_b,
               alu_out_write, alu_op, alu_ctrl_enable,
               inst_retired, is_halted};

  localparam logic [23:0] PCW  = 24'd1 << 20;
  localparam logic [23:0] PCS  = 24'd1 << 19;
  localparam logic [23:0] IOD  = 24'd1 << 18;
  localparam logic [23:0] MR   = 24'd1 << 17;
  localparam logic [23:0] MW   = 24'd1 << 16;
  localparam logic [23:0] IRW  = 24'd1 << 15;
  localparam logic [23:0] MDRW = 24'd1 << 14;
  localparam logic [23:0] REGW = 24'd1 << 13;
  localparam logic [23:0] WMDR = 24'd1 << 11;
  localparam logic [23:0] WPC4 = 24'd2 << 11;
  localparam logic [23:0] SA_A = 24'd1 << 10;
  localparam logic [23:0] SIMM = 24'd1 << 8;
  localparam logic [23:0] SB4  = 24'd2 << 8;
  localparam logic [23:0] AOW  = 24'd1 << 7;
  localparam logic [23:0] ACE  = 24'd1 << 2;
  localparam logic [23:0] RET  = 24'd1 << 1;
  localparam logic [23:0] HLT  = 24'd1;

  localparam logic [23:0] S_IF  = 24'd0 << 21;
  localparam logic [23:0] S_ID  = 24'd1 << 21;
  localparam logic [23:0] S_EX  = 24'd2 << 21;
  localparam logic [23:0] S_MEM = 24'd3 << 21;
  localparam logic [23:0] S_WB  = 24'd4 << 21;
  localparam logic [23:0] S_PCI = 24'd5 << 21;
  localparam logic [23:0] S_HLT = 24'd6 << 21;

  localparam logic [6:0] ADD  = 7'b0110011;
  localparam logic [6:0] ADDI = 7'b0010011;
  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] ECAL = 7'b1110011;
  localparam logic [6:0] LUI  = 7'b0110111;

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic        hlt;
    logic        bc;
    logic        rdy;
    logic [23:0] exp;
    string       nm;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic cyc(input logic r, input logic [6:0] o,
                     input logic h, input logic b,
                     input logic m, input logic [23:0] e,
                     input string nm);
    reset      = r;
    opcode     = o;
    ecall_halt = h;
    alu_bcond  = b;
    mem_ready  = m;
    #1;
    total++;
    if (ov !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, ov, e);
    end
    @(posedge clk);
    #1;
  endtask

  vec_t v[$];

  initial begin
    v.push_back('{1, ADD,  0, 0, 1, 24'd0, "reset0"});
    v.push_back('{1, ADD,  0, 0, 0, 24'd0, "reset1"});
    v.push_back('{0, ADD,  0, 0, 1, S_IF|MR|IRW, "add_if"});
    v.push_back('{0, ADD,  0, 0, 1, S_ID|SIMM|AOW, "add_id"});
    v.push_back('{0, ADD,  0, 0, 1, S_EX|SA_A|AOW|ACE, "add_ex"});
    v.push_back('{0, ADD,  0, 0, 1, S_WB|REGW|PCW|SB4, "add_wb"});
    v.push_back('{0, ADD,  0, 0, 0, S_IF|MR|RET, "add_ret"});
    v.push_back('{0, ADD,  0, 0, 0, S_IF|MR, "if_wait"});
    v.push_back('{0, LW,   0, 0, 1, S_IF|MR|IRW, "lw_if"});
    v.push_back('{0, LW,   0, 0, 1, S_ID|SIMM|AOW, "lw_id"});
    v.push_back('{0, LW,   0, 0, 1, S_EX|SA_A|SIMM|AOW, "lw_ex"});
    v.push_back('{0, LW,   0, 0, 0, S_MEM|IOD|MR, "lw_mw0"});
    v.push_back('{0, LW,   0, 0, 0, S_MEM|IOD|MR, "lw_mw1"});
    v.push_back('{0, LW,   0, 0, 0, S_MEM|IOD|MR, "lw_mw2"});
    v.push_back('{0, LW,   0, 0, 1, S_MEM|IOD|MR|MDRW, "lw_mrdy"});
    v.push_back('{0, LW,   0, 0, 1, S_WB|REGW|WMDR|PCW|SB4, "lw_wb"});
    v.push_back('{0, BEQ,  0, 0, 1, S_IF|MR|IRW|RET, "beq_if"});
    v.push_back('{0, BEQ,  0, 0, 1, S_ID|SIMM|AOW, "beq_id"});
    v.push_back('{0, BEQ,  0, 1, 1, S_EX|SA_A|ACE|PCW|PCS, "beq_t"});
    v.push_back('{0, BEQ,  0, 0, 1, S_IF|MR|IRW|RET, "beq2_if"});
    v.push_back('{0, BEQ,  0, 0, 1, S_ID|SIMM|AOW, "beq2_id"});
    v.push_back('{0, BEQ,  0, 0, 1, S_EX|SA_A|ACE, "beq_nt"});
    v.push_back('{0, BEQ,  0, 0, 1, S_PCI|SB4|PCW, "beq_pci"});
    v.push_back('{0, JAL,  0, 0, 1, S_IF|MR|IRW|RET, "jal_if"});
    v.push_back('{0, JAL,  0, 0, 1, S_ID|SIMM|AOW, "jal_id"});
    v.push_back('{0, JAL,  0, 0, 1, S_EX|SB4|REGW|WPC4|PCW|PCS, "jal_ex"});
    v.push_back('{0, JALR, 0, 0, 1, S_IF|MR|IRW|RET, "jalr_if"});
    v.push_back('{0, JALR, 0, 0, 1, S_ID|SIMM|AOW, "jalr_id"});
    v.push_back('{0, JALR, 0, 0, 1, S_EX|SA_A|SIMM|AOW, "jalr_ex"});
    v.push_back('{0, JALR, 0, 0, 1, S_WB|REGW|WPC4|PCW|PCS|SB4, "jalr_wb"});
    v.push_back('{0, SW,   0, 0, 1, S_IF|MR|IRW|RET, "sw_if"});
    v.push_back('{0, SW,   0, 0, 1, S_ID|SIMM|AOW, "sw_id"});
    v.push_back('{0, SW,   0, 0, 1, S_EX|SA_A|SIMM|AOW, "sw_ex"});
    v.push_back('{0, SW,   0, 0, 0, S_MEM|IOD|MW, "sw_mw"});
    v.push_back('{0, SW,   0, 0, 1, S_MEM|IOD|MW|SB4|PCW, "sw_mrdy"});
    v.push_back('{0, LUI,  0, 0, 1, S_IF|MR|IRW|RET, "unk_if"});
    v.push_back('{0, LUI,  0, 0, 1, S_ID|SIMM|AOW, "unk_id"});
    v.push_back('{0, LUI,  0, 0, 1, S_PCI|SB4|PCW, "unk_pci"});
    v.push_back('{0, ECAL, 0, 0, 1, S_IF|MR|IRW|RET, "ec0_if"});
    v.push_back('{0, ECAL, 0, 0, 1, S_ID|SIMM|AOW, "ec0_id"});
    v.push_back('{0, ECAL, 0, 0, 1, S_PCI|SB4|PCW, "ec0_pci"});
    v.push_back('{0, ADDI, 0, 0, 1, S_IF|MR|IRW|RET, "addi_if"});
    v.push_back('{0, ADDI, 0, 0, 1, S_ID|SIMM|AOW, "addi_id"});
    v.push_back('{0, ADDI, 0, 0, 1, S_EX|SA_A|SIMM|AOW|ACE, "addi_ex"});
    v.push_back('{0, ADDI, 0, 0, 1, S_WB|REGW|PCW|SB4, "addi_wb"});
    v.push_back('{0, ECAL, 0, 0, 1, S_IF|MR|IRW|RET, "ec1_if"});
    v.push_back('{0, ECAL, 1, 0, 1, S_ID|SIMM|AOW, "ec1_id"});

    for (int i = 0; i < v.size(); i++)
      cyc(v[i].rst, v[i].op, v[i].hlt, v[i].bc, v[i].rdy,
          v[i].exp, v[i].nm);

    // HALT absorbs regardless of inputs
    for (int i = 0; i < 10; i++)
      cyc(0, ADD, i[0], i[1], 1, S_HLT|HLT, "halt");

    cyc(1, ADD, 0, 0, 1, 24'd0, "halt_rst");
    cyc(0, LW,  0, 0, 1, S_IF|MR|IRW, "post_rst_if");
    cyc(0, LW,  0, 0, 1, S_ID|SIMM|AOW, "r_lw_id");
    cyc(0, LW,  0, 0, 1, S_EX|SA_A|SIMM|AOW, "r_lw_ex");
    cyc(0, LW,  0, 0, 0, S_MEM|IOD|MR, "r_lw_mem");
    cyc(1, LW,  0, 0, 0, 24'd0, "rst_in_mem");
    cyc(0, LW,  0, 0, 0, S_IF|MR, "after_mem_rst");
    cyc(1, LW,  0, 0, 0, 24'd0, "rst_in_if");
    cyc(0, LW,  0, 0, 0, S_IF|MR, "after_if_rst");
    cyc(0, LW,  0, 0, 0, S_IF|MR, "if_no_pulse");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
